keypad_debounce_enc: RTL and testbench

Front-end stage of the keypad input path. Synchronises the raw 10-key keypad lines, debounces presses and releases with a counter-based state machine, and encodes the pressed key into a 4-bit digit. Its outputs drive the keypad-driven counters downstream: `key_stable` is the clean level vector they compare against, and `key_valid` / `key_release` are single-cycle events. All glitches and bounce are absorbed here, so downstream blocks see at most one change per physical press or release.

---
 rtl/keypad_debounce_enc.sv | 147 ++++++++++++++
 tb/tb_keypad_debounce_enc.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_debounce_enc.sv
// Keypad front end: two-flop synchroniser, counter-based press/release debounce
// and one-hot to 4-bit digit encoding with single-cycle event pulses.
module keypad_debounce_enc #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [9:0] key_raw,
    output logic [9:0] key_stable,
    output logic [3:0] digit,
    output logic       key_valid,
    output logic       key_release,
    output logic       multi_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        HELD      = 2'd2,
        REL_DEB   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_nx;
    logic [9:0]       s1;
    logic [9:0]       s2;
    logic [9:0]       cand;
    logic [9:0]       cand_nx;
    logic [9:0]       stable_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [3:0]       digit_nx;
    logic [3:0]       enc;
    logic             valid_nx;
    logic             release_nx;
    logic             multi_nx;
    logic             one_hot;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= key_raw;
            s2 <= s1;
        end
    end

    // A vector is one-hot when it is non-zero and clearing its lowest set bit leaves nothing.
    assign one_hot = (cand != 10'd0) && ((cand & (cand - 10'd1)) == 10'd0);

    always_comb begin
        enc = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (cand[i]) begin
                enc = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state       <= IDLE;
            cand        <= '0;
            cnt         <= '0;
            key_stable  <= '0;
            digit       <= '0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            multi_err   <= 1'b0;
        end else begin
            state       <= state_nx;
            cand        <= cand_nx;
            cnt         <= cnt_nx;
            key_stable  <= stable_nx;
            digit       <= digit_nx;
            key_valid   <= valid_nx;
            key_release <= release_nx;
            multi_err   <= multi_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cand_nx    = cand;
        cnt_nx     = cnt;
        stable_nx  = key_stable;
        digit_nx   = digit;
        valid_nx   = 1'b0;
        release_nx = 1'b0;
        multi_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (s2 != 10'd0) begin
                    cand_nx  = s2;
                    cnt_nx   = CNT_ONE;
                    state_nx = PRESS_DEB;
                end
            end
            PRESS_DEB: begin
                if (s2 == 10'd0) begin
                    state_nx = IDLE;
                end else if (s2 != cand) begin
                    cand_nx = s2;
                    cnt_nx  = CNT_ONE;
                end else if (cnt < CNT_LAST) begin
                    cnt_nx = cnt + CNT_ONE;
                end else begin
                    state_nx  = HELD;
                    stable_nx = cand;
                    if (one_hot) begin
                        digit_nx = enc;
                        valid_nx = 1'b1;
                    end else begin
                        multi_nx = 1'b1;
                    end
                end
            end
            HELD: begin
                if (s2 != cand) begin
                    cnt_nx   = CNT_ONE;
                    state_nx = REL_DEB;
                end
            end
            REL_DEB: begin
                // Any sample that differs from the held key counts toward release.
                if (s2 == cand) begin
                    state_nx = HELD;
                end else if (cnt < CNT_LAST) begin
                    cnt_nx = cnt + CNT_ONE;
                end else begin
                    stable_nx  = 10'd0;
                    release_nx = 1'b1;
                    state_nx   = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_debounce_enc.sv
// Bench for keypad_debounce_enc: run-length reference model checked every cycle,
// a vector table of press/hold cases, and directed multi-cycle sequences.
module tb_keypad_debounce_enc;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic [9:0] key_raw = 10'd0;
    logic [9:0] key_stable;
    logic [3:0] digit;
    logic       key_valid;
    logic       key_release;
    logic       multi_err;

    keypad_debounce_enc #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .key_raw    (key_raw),
        .key_stable (key_stable),
        .digit      (digit),
        .key_valid  (key_valid),
        .key_release(key_release),
        .multi_err  (multi_err)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc, valid_cnt, rel_cnt, multi_cnt, valid_cyc, rel_cyc, acc_cyc;
    logic [9:0] accept_stable;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // Reference model: s2 is raw delayed by two samples; a press is accepted on the
    // D-th consecutive identical non-zero sample, a release on the D-th consecutive
    // sample that differs from the accepted vector.
    logic [9:0] m_p1, m_p2, m_cand, m_stable;
    logic [3:0] m_digit;
    logic       m_valid, m_rel, m_multi, m_held;
    int         m_run, m_mrun;

    function automatic logic [3:0] idx_of(input logic [9:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 10; i++) if (v[i]) r = 4'(i);
        return r;
    endfunction

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_cand = '0; m_stable = '0; m_digit = '0;
        m_valid = 0; m_rel = 0; m_multi = 0; m_held = 0; m_run = 0; m_mrun = 0;
    endtask

    task automatic model_step();
        logic [9:0] s;
        s = m_p2;
        m_valid = 0; m_rel = 0; m_multi = 0;
        if (!m_held) begin
            if (s == 10'd0) m_run = 0;
            else if (m_run > 0 && s == m_cand) m_run++;
            else begin m_cand = s; m_run = 1; end
            if (m_run == D) begin
                m_held = 1; m_mrun = 0; m_stable = s;
                if ($countones(s) == 1) begin m_digit = idx_of(s); m_valid = 1; end
                else m_multi = 1;
            end
        end else begin
            if (s == m_cand) m_mrun = 0; else m_mrun++;
            if (m_mrun == D) begin
                m_held = 0; m_run = 0; m_stable = '0; m_rel = 1;
            end
        end
        m_p2 = m_p1;
        m_p1 = key_raw;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge clear_n);
            if (!clear_n) model_reset(); else model_step();
        end
    end

    task automatic clear_log();
        cyc = 0; valid_cnt = 0; rel_cnt = 0; multi_cnt = 0;
        valid_cyc = -1; rel_cyc = -1; acc_cyc = -1; accept_stable = '0;
    endtask

    // Drive one raw sample at the falling edge, then compare a cycle later.
    task automatic tick(input logic [9:0] raw);
        key_raw = raw;
        @(negedge clk);
        cyc++;
        check("key_stable", 32'(key_stable), 32'(m_stable));
        check("digit", 32'(digit), 32'(m_digit));
        check("key_valid", 32'(key_valid), 32'(m_valid));
        check("key_release", 32'(key_release), 32'(m_rel));
        check("multi_err", 32'(multi_err), 32'(m_multi));
        check("pulse_exclusive", 32'((int'(key_valid) + int'(key_release) + int'(multi_err)) <= 1), 32'd1);
        if (key_valid) begin valid_cnt++; valid_cyc = cyc; end
        if (key_release) begin rel_cnt++; rel_cyc = cyc; end
        if (multi_err) multi_cnt++;
        if ((key_valid || multi_err) && acc_cyc < 0) begin acc_cyc = cyc; accept_stable = key_stable; end
    endtask

    typedef struct {
        logic [9:0] raw;
        int         hold;
        logic [3:0] exp_digit;
        int         exp_valid;
        int         exp_multi;
        int         exp_acc_cyc;
        int         exp_rel_cyc;
        logic [9:0] exp_acc_stable;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{10'h200, 20, 4'd9, 1, 0, 10, 30, 10'h200};
        vecs[1] = '{10'h004,  8, 4'd2, 1, 0, 10, 18, 10'h004};
        vecs[2] = '{10'h040,  7, 4'd2, 0, 0, -1, -1, 10'h000};
        vecs[3] = '{10'h003, 12, 4'd2, 0, 1, 10, 22, 10'h003};
        vecs[4] = '{10'h001, 10, 4'd0, 1, 0, 10, 20, 10'h001};
        vecs[5] = '{10'h300,  9, 4'd0, 0, 1, 10, 19, 10'h300};
        vecs[6] = '{10'h100, 15, 4'd8, 1, 0, 10, 25, 10'h100};

        // Reset held with a key down: everything idle.
        clear_log();
        key_raw = 10'h004;
        repeat (3) @(negedge clk);
        check("rst_stable", 32'(key_stable), 32'd0);
        check("rst_digit", 32'(digit), 32'd0);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_release", 32'(key_release), 32'd0);
        check("rst_multi", 32'(multi_err), 32'd0);
        clear_n = 1'b1;
        repeat (12) tick(10'h004);
        check("rst_press_count", 32'(valid_cnt), 32'd1);
        check("rst_press_cycle", 32'(valid_cyc), 32'd10);
        check("rst_press_digit", 32'(digit), 32'd2);
        check("rst_press_stable", 32'(key_stable), 32'h004);
        repeat (16) tick(10'h000);
        check("rst_release_cycle", 32'(rel_cyc), 32'd22);

        // Vector table: press for 'hold' cycles, then release.
        for (int v = 0; v < 7; v++) begin
            clear_log();
            repeat (vecs[v].hold) tick(vecs[v].raw);
            repeat (14) tick(10'h000);
            check("vec_valid_count", 32'(valid_cnt), 32'(vecs[v].exp_valid));
            check("vec_multi_count", 32'(multi_cnt), 32'(vecs[v].exp_multi));
            check("vec_accept_cycle", 32'(acc_cyc), 32'(vecs[v].exp_acc_cyc));
            check("vec_accept_stable", 32'(accept_stable), 32'(vecs[v].exp_acc_stable));
            check("vec_release_cycle", 32'(rel_cyc), 32'(vecs[v].exp_rel_cyc));
            check("vec_digit", 32'(digit), 32'(vecs[v].exp_digit));
        end

        // Press bounce: toggles every 3 cycles for 12 cycles, then stable.
        clear_log();
        for (int k = 0; k < 12; k++) tick(((k / 3) % 2 == 0) ? 10'h001 : 10'h000);
        repeat (14) tick(10'h001);
        check("bounce_valid_count", 32'(valid_cnt), 32'd1);
        check("bounce_valid_cycle", 32'(valid_cyc), 32'd22);
        check("bounce_digit", 32'(digit), 32'd0);
        repeat (14) tick(10'h000);

        // Release glitch on key 5: 4-cycle drop must not release.
        clear_log();
        repeat (12) tick(10'h020);
        for (int k = 0; k < 20; k++) begin
            tick((k < 4) ? 10'h000 : 10'h020);
            check("glitch_stable", 32'(key_stable), 32'h020);
        end
        check("glitch_no_release", 32'(rel_cnt), 32'd0);
        check("glitch_single_valid", 32'(valid_cnt), 32'd1);
        repeat (14) tick(10'h000);
        check("glitch_final_release", 32'(rel_cnt), 32'd1);

        // Key change while held: key 3 then directly key 7.
        clear_log();
        repeat (12) tick(10'h008);
        check("change_first_digit", 32'(digit), 32'd3);
        clear_log();
        repeat (20) tick(10'h080);
        check("change_release_cycle", 32'(rel_cyc), 32'd10);
        check("change_valid_cycle", 32'(valid_cyc), 32'd18);
        check("change_digit", 32'(digit), 32'd7);
        check("change_stable", 32'(key_stable), 32'h080);
        repeat (14) tick(10'h000);

        // Asynchronous clear mid-hold, then a still-held key is a fresh press.
        clear_log();
        repeat (12) tick(10'h020);
        #2 clear_n = 1'b0;
        #1;
        check("async_stable", 32'(key_stable), 32'd0);
        check("async_digit", 32'(digit), 32'd0);
        @(negedge clk);
        clear_n = 1'b1;
        clear_log();
        repeat (12) tick(10'h020);
        check("async_repress_cycle", 32'(valid_cyc), 32'd10);
        check("async_repress_digit", 32'(digit), 32'd5);
        repeat (14) tick(10'h000);

        // Random segments with bounce, compared every cycle against the model.
        begin
            logic [9:0] pat;
            int sel, hold;
            pat = 10'd0;
            for (int seg = 0; seg < 200; seg++) begin
                sel = $urandom_range(0, 9);
                if (sel <= 5) pat = 10'(1 << $urandom_range(0, 9));
                else if (sel == 6) pat = 10'd0;
                else if (sel == 7) pat = 10'($urandom);
                hold = $urandom_range(1, 14);
                for (int k = 0; k < hold; k++) begin
                    if (sel >= 8 && $urandom_range(0, 5) == 0) tick(10'($urandom));
                    else tick(pat);
                end
                if (seg == 100) begin
                    #2 clear_n = 1'b0;
                    @(negedge clk);
                    clear_n = 1'b1;
                end
            end
            repeat (20) tick(10'h000);
            check("random_end_stable", 32'(key_stable), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
